// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet/IPv4/UDP receive constants and state encodings
package eth_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PREAMBLE = 4'd1,
        ST_MAC      = 4'd2,
        ST_HEADER   = 4'd3,
        ST_DATA     = 4'd4,
        ST_TAIL     = 4'd5,
        ST_DONE     = 4'd6,
        ST_DROP     = 4'd7
    } rx_state_t;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [31:0] CRC_POLY       = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-wide Ethernet CRC-32 register with enable and synchronous init
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    // MSB-first shift with each byte fed LSB first: the register holds the
    // bit-reversed form of the reflected CRC, so a good frame leaves 0xC704DD7B
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[31] ^ data[i])
                crc_next = {crc_next[30:0], 1'b0} ^ CRC_POLY;
            else
                crc_next = {crc_next[30:0], 1'b0};
        end
    end

    // Init to all-ones takes priority over accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= 32'h0;
        else if (init)
            crc <= 32'hFFFF_FFFF;
        else if (en)
            crc <= crc_next;
    end

endmodule

// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - GMII UDP/IPv4 receive parser writing payload words to packet RAM (FCS check under UDP_RX_FCS_CHECK_EN)
module udp_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
    parameter logic [15:0] LOCAL_PORT = 16'h1F90,
    parameter int          MAX_WORDS  = 512
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        rxdv,
    input  logic        rxer,
    input  logic [7:0]  datain,
    output logic        ram_wr_en,
    output logic [8:0]  ram_wr_addr,
    output logic [31:0] ram_wr_data,
    output logic [15:0] rx_data_length,
    output logic        rx_done,
    output logic        rx_err,
    output logic [3:0]  rx_state
);

    localparam logic [16:0] MAX_UDP_LEN = 17'(8 + 4 * MAX_WORDS);

    rx_state_t   state;
    logic        prev_low;   // rxdv was low last cycle; a frame may only start after this
    logic [15:0] cnt;        // byte index within the current section
    logic [39:0] hsr;        // last five header bytes
    logic [47:0] hsr_next;
    logic        filt_ok;    // no filter mismatch seen yet in this section
    logic        byte_bad;
    logic [15:0] pay_len;
    logic [23:0] word_sr;    // upper bytes of the word being assembled
    logic [31:0] word_next;
    logic        pay_last;
    logic        rx_fault;
    logic        fcs_ok;

    assign hsr_next = {hsr, datain};
    assign pay_last = (cnt == pay_len - 16'd1);
    assign rx_fault = !rxdv || rxer;
    assign rx_state = state;

`ifdef UDP_RX_FCS_CHECK_EN
    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc_val;

    assign crc_init = (state == ST_PREAMBLE) && rxdv && (datain == SFD_BYTE);
    assign crc_en   = rxdv && ((state == ST_MAC) || (state == ST_HEADER) ||
                               (state == ST_DATA) || (state == ST_TAIL));
    assign fcs_ok   = (crc_val == CRC_RESIDUE);

    crc32_d8 u_crc (
        .clk   (clk),
        .rst_n (clr),
        .init  (crc_init),
        .en    (crc_en),
        .data  (datain),
        .crc   (crc_val)
    );
`else
    assign fcs_ok = 1'b1;
`endif

    // Per-byte filter check for the field completed by the current byte
    always_comb begin
        byte_bad = 1'b0;
        if (state == ST_MAC) begin
            if (cnt == 16'd5)
                byte_bad = !((hsr_next == LOCAL_MAC) || (hsr_next == 48'hFFFF_FFFF_FFFF));
            else if (cnt == 16'd13)
                byte_bad = (hsr_next[15:0] != ETHERTYPE_IPV4);
        end else if (state == ST_HEADER) begin
            if (cnt == 16'd0)
                byte_bad = (datain != IPV4_VER_IHL);
            else if (cnt == 16'd9)
                byte_bad = (datain != IP_PROTO_UDP);
            else if (cnt == 16'd19)
                byte_bad = (hsr_next[31:0] != LOCAL_IP);
            else if (cnt == 16'd23)
                byte_bad = (hsr_next[15:0] != LOCAL_PORT);
            else if (cnt == 16'd25)
                byte_bad = (hsr_next[15:0] <= 16'd8) || ({1'b0, hsr_next[15:0]} > MAX_UDP_LEN);
        end
    end

    // Place the current payload byte into its lane; lanes not yet filled stay 0
    always_comb begin
        case (cnt[1:0])
            2'd0:    word_next = {datain, 24'h0};
            2'd1:    word_next = {word_sr[23:16], datain, 16'h0};
            2'd2:    word_next = {word_sr[23:8], datain, 8'h0};
            default: word_next = {word_sr, datain};
        endcase
    end

    // Receive FSM with registered RAM strobe and status pulses
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state          <= ST_IDLE;
            prev_low       <= 1'b0;
            cnt            <= 16'd0;
            hsr            <= 40'h0;
            filt_ok        <= 1'b0;
            pay_len        <= 16'd0;
            word_sr        <= 24'h0;
            ram_wr_en      <= 1'b0;
            ram_wr_addr    <= 9'd0;
            ram_wr_data    <= 32'h0;
            rx_data_length <= 16'd0;
            rx_done        <= 1'b0;
            rx_err         <= 1'b0;
        end else begin
            ram_wr_en <= 1'b0;
            rx_done   <= 1'b0;
            rx_err    <= 1'b0;
            prev_low  <= !rxdv;
            hsr       <= hsr_next[39:0];
            if (ram_wr_en)
                ram_wr_addr <= ram_wr_addr + 9'd1;

            case (state)
                ST_IDLE: begin
                    if (rxdv && prev_low && datain == PREAMBLE_BYTE) begin
                        state <= ST_PREAMBLE;
                        cnt   <= 16'd1;
                    end
                end
                ST_PREAMBLE: begin
                    if (rx_fault) begin
                        state <= ST_DROP;
                    end else if (datain == SFD_BYTE) begin
                        state   <= ST_MAC;
                        cnt     <= 16'd0;
                        filt_ok <= 1'b1;
                    end else if (datain == PREAMBLE_BYTE && cnt < 16'd7) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        state <= ST_DROP;
                    end
                end
                ST_MAC: begin
                    if (rx_fault) begin
                        state <= ST_DROP;
                    end else if (cnt == 16'd13) begin
                        state   <= (filt_ok && !byte_bad) ? ST_HEADER : ST_DROP;
                        cnt     <= 16'd0;
                        filt_ok <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (byte_bad)
                            filt_ok <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    if (rx_fault) begin
                        state  <= ST_DROP;
                        rx_err <= 1'b1;
                    end else if (cnt == 16'd27) begin
                        state       <= filt_ok ? ST_DATA : ST_DROP;
                        cnt         <= 16'd0;
                        ram_wr_addr <= 9'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (byte_bad)
                            filt_ok <= 1'b0;
                        if (cnt == 16'd25)
                            pay_len <= hsr_next[15:0] - 16'd8;
                    end
                end
                ST_DATA: begin
                    if (rx_fault) begin
                        state  <= ST_DROP;
                        rx_err <= 1'b1;
                    end else begin
                        word_sr     <= word_next[31:8];
                        ram_wr_data <= word_next;
                        if (cnt[1:0] == 2'd3 || pay_last)
                            ram_wr_en <= 1'b1;
                        if (pay_last)
                            state <= ST_TAIL;
                        else
                            cnt <= cnt + 16'd1;
                    end
                end
                ST_TAIL: begin
                    if (rxer) begin
                        state  <= ST_DROP;
                        rx_err <= 1'b1;
                    end else if (!rxdv) begin
                        state <= ST_DONE;
                        if (fcs_ok) begin
                            rx_done        <= 1'b1;
                            rx_data_length <= pay_len;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // A one-cycle gap puts the next preamble byte here, so accept it
                    if (rxdv && prev_low && datain == PREAMBLE_BYTE) begin
                        state <= ST_PREAMBLE;
                        cnt   <= 16'd1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (!rxdv)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
